// File: rtl/port_uart_tx_pkg.sv
// Shared definitions for the port-mapped UART transmitter: FSM encoding,
// status/control bit positions and the status-byte packer.
package port_uart_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_ACK    = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_CNT_LO = 5;
    localparam int ST_CNT_HI = 7;

    localparam int CT_REQ    = 0;
    localparam int CT_OVFCLR = 1;

    function automatic logic [7:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       ack,
        input logic       ovf,
        input logic [2:0] cnt
    );
        logic [7:0] s;
        s                       = '0;
        s[ST_BUSY]              = busy;
        s[ST_FULL]              = full;
        s[ST_EMPTY]             = empty;
        s[ST_ACK]               = ack;
        s[ST_OVF]               = ovf;
        s[ST_CNT_HI:ST_CNT_LO]  = cnt;
        return s;
    endfunction

endpackage

// File: rtl/port_uart_tx_fifo_sync.sv
// Small byte FIFO: synchronous write, read data taken from the register array
// at the read pointer; push while full and pop while empty are ignored.
module fifo_sync #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wr_data,
    output logic [7:0]         rd_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = DEPTH[FIFO_AW:0];

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly FIFO_AW bits wide, so they wrap modulo depth on their own.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// UART 8N1 transmitter fed from CPU output ports: toggle-based request
// detection, byte FIFO, serial shifter and a pollable status byte.
module port_uart_tx
    import port_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] ctrl_in,
    output logic [7:0] status_out,
    output logic       tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t          state;
    logic               req_q;
    logic               ack;
    logic               overflow;
    logic [7:0]         shift;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_idx;

    logic               req_event;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_rd_data;
    logic [FIFO_AW:0]   fifo_count;
    logic               unused_ctrl;

    assign unused_ctrl = ^ctrl_in[7:2];

    assign req_event = ctrl_in[CT_REQ] ^ req_q;
    assign push      = req_event && !fifo_full;
    assign pop       = (state == TX_IDLE) && !fifo_empty;

    fifo_sync #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A request dropped on a full FIFO still acks; a drop beats a clear on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q    <= 1'b0;
            ack      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            req_q <= ctrl_in[CT_REQ];
            if (req_event) begin
                ack <= ctrl_in[CT_REQ];
            end
            if (req_event && fifo_full) begin
                overflow <= 1'b1;
            end else if (ctrl_in[CT_OVFCLR]) begin
                overflow <= 1'b0;
            end
        end
    end

    // tx is registered and loaded with the next bit's level on each transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= TX_IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_rd_data;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= TX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

    assign status_out = pack_status((state != TX_IDLE) || !fifo_empty,
                                    fifo_full, fifo_empty, ack, overflow,
                                    3'(fifo_count));

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx (CLKS_PER_BIT=4, FIFO_AW=2) with a
// line receiver that decodes every frame seen on tx.
module tb_port_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic [7:0] ctrl_in;
    logic [7:0] status_out;
    logic       tx;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cycle  = 0;

    logic [7:0] rx_data  [$];
    int         rx_cycle [$];
    bit         rx_ok    [$];

    port_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_AW      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .ctrl_in    (ctrl_in),
        .status_out (status_out),
        .tx         (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] c);
        data_in = d;
        ctrl_in = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line receiver: detects a start bit on the falling edge and samples mid-bit.
    initial begin
        logic [7:0] b;
        bit         ok;
        int         start_cyc;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                start_cyc = cycle;
                ok = 1'b1;
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                rx_data.push_back(b);
                rx_cycle.push_back(start_cyc);
                rx_ok.push_back(ok);
            end
        end
    end

    initial begin
        bit stable;
        bit tx_low_seen;
        int n0;

        // Scenario 1: reset and quiet idle
        reset = 1'b0;
        applyStimulus(8'h00, 8'h00);
        tick(3);
        checkOutput("s1_reset_status", status_out, 8'h04);
        checkOutput("s1_reset_tx", tx, 1'b1);
        reset = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            tick(1);
            if (status_out !== 8'h04 || tx !== 1'b1) stable = 1'b0;
        end
        checkOutput("s1_idle_stable", stable, 1'b1);

        // Scenario 2: one byte 0xA5
        applyStimulus(8'hA5, 8'h01);
        tick(1);
        checkOutput("s2_push_tx_high", tx, 1'b1);
        checkOutput("s2_push_status", status_out, 8'h29);
        tick(1);
        checkOutput("s2_start_tx_low", tx, 1'b0);
        checkOutput("s2_start_status", status_out, 8'h0D);
        tick(39);
        checkOutput("s2_stop_status", status_out, 8'h0D);
        tick(1);
        checkOutput("s2_done_status", status_out, 8'h0C);
        checkOutput("s2_rx_count", rx_data.size(), 1);
        checkOutput("s2_rx_byte", rx_data[0], 8'hA5);
        checkOutput("s2_rx_framing", rx_ok[0], 1'b1);

        // Scenario 3: six back-to-back toggles, sixth is dropped
        applyStimulus(8'h01, 8'h00);
        tick(1);
        applyStimulus(8'h02, 8'h01);
        tick(1);
        applyStimulus(8'h03, 8'h00);
        tick(1);
        applyStimulus(8'h04, 8'h01);
        tick(1);
        applyStimulus(8'h05, 8'h00);
        tick(1);
        checkOutput("s3_full_status", status_out, 8'h83);
        applyStimulus(8'h06, 8'h01);
        tick(1);
        checkOutput("s3_drop_status", status_out, 8'h9B);

        // Scenario 4: overflow clear, then drop and clear on one edge
        applyStimulus(8'h06, 8'h03);
        tick(1);
        checkOutput("s4_clear_status", status_out, 8'h8B);
        applyStimulus(8'h77, 8'h02);
        tick(1);
        checkOutput("s4_set_wins_status", status_out, 8'h93);
        applyStimulus(8'h77, 8'h02);
        tick(1);
        checkOutput("s4_reclear_status", status_out, 8'h83);
        applyStimulus(8'h00, 8'h00);
        tick(200);
        checkOutput("s3_drained_status", status_out, 8'h04);
        checkOutput("s3_rx_count", rx_data.size(), 6);
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("s3_rx_byte%0d", k), rx_data[k], k);
            checkOutput($sformatf("s3_rx_framing%0d", k), rx_ok[k], 1'b1);
        end
        for (int k = 2; k <= 5; k++) begin
            checkOutput($sformatf("s3_spacing%0d", k), rx_cycle[k] - rx_cycle[k-1], 41);
        end

        // Scenario 5: reset during DATA bit 3 of 0x3C with two bytes queued
        n0 = rx_data.size();
        applyStimulus(8'h3C, 8'h01);
        tick(1);
        applyStimulus(8'h11, 8'h00);
        tick(1);
        applyStimulus(8'h22, 8'h01);
        tick(1);
        checkOutput("s5_queued_status", status_out, 8'h49);
        tick(15);
        reset = 1'b0;
        applyStimulus(8'h00, 8'h00);
        tick(1);
        checkOutput("s5_abort_tx", tx, 1'b1);
        checkOutput("s5_abort_status", status_out, 8'h04);
        reset = 1'b1;
        tx_low_seen = 1'b0;
        stable = 1'b1;
        repeat (100) begin
            tick(1);
            if (tx !== 1'b1) tx_low_seen = 1'b1;
            if (status_out !== 8'h04) stable = 1'b0;
        end
        checkOutput("s5_line_quiet", tx_low_seen, 1'b0);
        checkOutput("s5_status_stable", stable, 1'b1);
        checkOutput("s5_rx_count", rx_data.size(), n0 + 1);

        // Scenario 6: push lands on the pop edge with count=1
        applyStimulus(8'h5A, 8'h01);
        tick(1);
        checkOutput("s6_first_status", status_out, 8'h29);
        applyStimulus(8'hC3, 8'h00);
        tick(1);
        checkOutput("s6_pushpop_status", status_out, 8'h21);
        checkOutput("s6_start_tx_low", tx, 1'b0);
        tick(90);
        checkOutput("s6_drained_status", status_out, 8'h04);
        checkOutput("s6_rx_count", rx_data.size(), n0 + 3);
        checkOutput("s6_rx_byte0", rx_data[n0 + 1], 8'h5A);
        checkOutput("s6_rx_byte1", rx_data[n0 + 2], 8'hC3);
        checkOutput("s6_rx_framing", rx_ok[n0 + 1] & rx_ok[n0 + 2], 1'b1);
        checkOutput("s6_spacing", rx_cycle[n0 + 2] - rx_cycle[n0 + 1], 41);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Memory-mapped serial transmitter that sits directly downstream of the single-cycle CPU's output ports.
- Consumes the data port (out_p0) and the control port (out_p1), buffers bytes in a small FIFO, and shifts them out as UART 8N1.
- Returns a status byte to a CPU input port (in_p0) so software can poll for space, completion and overflow.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range is 2 and above.
- FIFO_AW, 2: FIFO address width; depth is 2**FIFO_AW; legal values are 1 and 2, so the count fits the 3-bit status field.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
- data_in  in  8  byte to send; driven from CPU out_p0.
- ctrl_in  in  8  control; driven from CPU out_p1. Bit0 = request toggle; bit1 = overflow clear (level); bits 7:2 ignored.
- status_out  out  8  to CPU in_p0. Bits: 0 busy, 1 full, 2 empty, 3 ack, 4 overflow, 7:5 FIFO count.
- tx  out  1  serial line; idles high.

Behaviour:
Reset:
- FIFO pointers and count = 0.
- req_q = 0, ack = 0, overflow = 0, FSM = IDLE, tx = 1.
- status_out = 0x04.
- Reset mid-frame aborts the frame: tx = 1 from the reset edge onward, and buffered bytes are discarded.

Request detection:
- req_q registers ctrl_in[0] every cycle.
- A request event occurs when ctrl_in[0] != req_q.
- On the event edge, if FIFO not full: push data_in.
- If FIFO full: drop the byte and set overflow (sticky).
- ack <= ctrl_in[0] on every event, whether accepted or dropped, so software detects completion by ack matching its toggle.
- Full is evaluated on pre-edge state; a push while full is rejected even if a pop occurs on the same edge.
- Overflow clears on any edge where ctrl_in[1]=1. If a set and a clear coincide, the set wins.

FIFO:
- Synchronous write, registered read.
- Simultaneous push and pop with 0 < count < depth leaves count unchanged.
- Pointers wrap modulo depth.

TX FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If FIFO not empty: pop into shift register, clear baud counter and bit index, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; send 8 bits, LSB first; then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- One IDLE cycle separates back-to-back frames, so frame period = 10*CLKS_PER_BIT+1 cycles.

Latency:
- CPU writes ports at edge E0; event detected and byte pushed at E1.
- FSM pops at E2; tx falls immediately after E2.

Status flags:
- busy = (FSM != IDLE) or not empty.
- full = (count == depth); empty = (count == 0).
- status_out is a registered/combinational function of state only; it never depends combinationally on ctrl_in or data_in.
- Baud counter width = clog2(CLKS_PER_BIT).

Decomposition:
- Shared header io_defs.vh holds:
  - FSM state encodings (2-bit);
  - status bit positions (ST_BUSY=0, ST_FULL=1, ST_EMPTY=2, ST_ACK=3, ST_OVF=4, ST_CNT=7:5);
  - control bit positions (CT_REQ=0, CT_OVFCLR=1).
- One sub-module, fifo_sync: parameterised byte FIFO with push, pop, full, empty and count.
- The FSM, shifter, baud counter and request detect stay in port_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2):
1. Reset held 3 cycles with ctrl_in=0 -> status_out=0x04, tx=1; both stay stable for 20 idle cycles.
2. data_in=0xA5, toggle ctrl_in[0] 0->1 -> tx low 2 cycles after the write edge. Mid-bit samples read start 0, then 1,0,1,0,0,1,0,1, then stop 1. Frame = 40 cycles. Final status_out=0x0C.
3. Six toggles one cycle apart with data 0x01..0x06:
   - 0x01 popped immediately; 0x02..0x05 fill the FIFO; 0x06 dropped.
   - status_out=0x9B (count 4, ovf, ack, full, busy).
   - Line carries 0x01..0x05 in order, with 41-cycle frame spacing.
4. After scenario 3, ctrl_in[1]=1 for one cycle -> bit4 clears. A drop and a clear on the same edge -> bit4 stays 1.
5. Assert reset during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 from that edge, status_out=0x04, no further frames over 100 cycles.
6. Toggle twice so that a push lands on the pop edge with count=1 -> count stays 1, both bytes are transmitted, no overflow.
